unsigned_binary_divider: RTL and testbench
==========================================

// Module: unsigned_binary_divider
// PURPOSE
//  Sequential unsigned divider: the inverse of the 16x4 shift-add multiplier.
//  Divides a 20-bit dividend (a multiplier product) by a 4-bit divisor and
//  returns a 16-bit quotient and a 4-bit remainder, one quotient bit per clock.
//  Sits beside the multiplier in the arithmetic datapath and uses the same St/Done
//  start/complete handshake.
// PARAMETERS
//  Q_W  16  quotient width, i.e. the multiplier width (dividend width = Q_W+D_W)
//  D_W  4   divisor width, i.e. the multiplicand width (remainder width = D_W)
// PORTS
//  clk       in   1          rising-edge clock
//  rst       in   1          asynchronous active-high reset
//  St        in   1          start request; sampled only in IDLE
//  Dividend  in   Q_W+D_W    dividend, captured when St is accepted
//  Divisor   in   D_W        divisor, captured when St is accepted
//  Quotient  out  Q_W        result quotient; held until next completion
//  Remainder out  D_W        result remainder; held until next completion
//  Ovf       out  1          divide-by-zero or quotient overflow; held with result
//  Done      out  1          one-cycle pulse: Quotient/Remainder/Ovf are valid
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-division): state=IDLE, iteration count=0,
//    Quotient=0, Remainder=0, Ovf=0, Done=0. Operation in progress is discarded.
//  - States: IDLE -> CHECK -> DIV (Q_W cycles) -> DONE -> IDLE.
//  - IDLE: on an edge with St=1, capture Dividend/Divisor into working registers
//    and go to CHECK. St=0 stays IDLE. St is ignored in every other state.
//  - CHECK (1 cycle): Ovf condition = (Divisor==0) or
//    (Dividend[Q_W+D_W-1:Q_W] >= Divisor). If set -> DONE with Quotient=0,
//    Remainder=0, Ovf=1. Else partial remainder R (D_W+1 bits) =
//    {0, Dividend upper D_W bits}, count=0, -> DIV.
//  - DIV (restoring, MSB first): each cycle T = {R[D_W-1:0], next dividend bit};
//    if T >= Divisor: R = T - Divisor, shift 1 into quotient, else R = T, shift 0.
//    After iteration Q_W-1 (count wraps) go to DONE; Quotient, Remainder loaded
//    from working registers with Ovf=0 on that same edge.
//  - DONE (1 cycle): Done=1 (decoded from state register, glitch-free); -> IDLE.
//    A new St may be accepted on the edge leaving DONE->IDLE only from IDLE, i.e.
//    St in DONE is ignored; earliest new accept is the following edge.
//  - Latency: St accepted on edge 0; normal: Done high in the cycle after edge
//    Q_W+1 (edge 17 by default) ; overflow: Done high in cycle after edge 1.
//  - Quotient/Remainder/Ovf change only on the edge entering DONE (and on reset);
//    stable at all other times, including while Done=0 and during a new division.
//  - Invariant when Ovf=0: Quotient*Divisor + Remainder == Dividend,
//    Remainder < Divisor. All arithmetic unsigned, no truncation of R (D_W+1 bits).
// TESTING
//  1 Dividend=200, Divisor=7, St pulse -> Done 17 cycles after accept, Quotient=28,
//    Remainder=4, Ovf=0; Done high exactly one cycle.
//  2 Round trip: Dividend=0x0A3D4 (0x1234*9), Divisor=9 -> Quotient=0x1234,
//    Remainder=0; Dividend=0xEFFFF, Divisor=15 -> Quotient=0xFFFF, Remainder=14.
//  3 Overflow: Dividend=0xF0000, Divisor=15 -> Ovf=1, Quotient=0, Remainder=0, Done
//    1 cycle after CHECK; Divisor=0, any Dividend -> same Ovf response.
//  4 St held high / re-pulsed during DIV and DONE -> ignored; outputs stay at the
//    previous result until the in-flight division completes; back-to-back runs OK.
//  5 Assert rst during DIV iteration 8 -> all outputs 0 immediately, no Done pulse;
//    fresh St after release gives a correct result (e.g. 100/3 -> 33 r 1).
//  6 Random 1000 pairs vs. reference model; check invariant and Ovf rule.

Source files
------------

// File: rtl/unsigned_binary_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Pairs with the shift-add multiplier through the St/Done handshake.
module unsigned_binary_divider #(
    parameter int Q_W = 16,
    parameter int D_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               St,
    input  logic [Q_W+D_W-1:0] Dividend,
    input  logic [D_W-1:0]     Divisor,
    output logic [Q_W-1:0]     Quotient,
    output logic [D_W-1:0]     Remainder,
    output logic               Ovf,
    output logic               Done
);

    localparam int N_W   = Q_W + D_W;
    localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DIV,
        DONE
    } state_t;

    state_t            state;
    logic [N_W-1:0]    dvd;
    logic [D_W-1:0]    dvs;
    logic [D_W:0]      part;
    logic [Q_W-1:0]    q_work;
    logic [CNT_W-1:0]  cnt;

    logic [D_W:0]      trial;
    logic              fits;
    logic [D_W:0]      part_next;
    logic [Q_W-1:0]    q_next;
    logic              ovf_cond;
    logic              last;

    // One restoring step: bring down the next dividend bit and try a subtract.
    // The partial remainder stays below the divisor, so its top bit can be
    // dropped when forming the trial value without losing information.
    always_comb begin
        trial     = {part[D_W-1:0], dvd[Q_W-1]};
        fits      = (trial >= {1'b0, dvs});
        part_next = fits ? (trial - {1'b0, dvs}) : trial;
        q_next    = {q_work[Q_W-2:0], fits};
        ovf_cond  = (dvs == '0) || (dvd[N_W-1:Q_W] >= dvs);
        last      = (cnt == CNT_W'(Q_W - 1));
    end

    // Control FSM plus working and result registers; results load only on
    // the edge that enters DONE, so they hold steady through a new run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            part      <= '0;
            q_work    <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (St) begin
                        dvd   <= Dividend;
                        dvs   <= Divisor;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (ovf_cond) begin
                        Quotient  <= '0;
                        Remainder <= '0;
                        Ovf       <= 1'b1;
                        state     <= DONE;
                    end else begin
                        part   <= {1'b0, dvd[N_W-1:Q_W]};
                        q_work <= '0;
                        cnt    <= '0;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    part            <= part_next;
                    q_work          <= q_next;
                    dvd[Q_W-1:0]    <= {dvd[Q_W-2:0], 1'b0};
                    cnt             <= cnt + CNT_W'(1);
                    if (last) begin
                        Quotient  <= q_next;
                        Remainder <= part_next[D_W-1:0];
                        Ovf       <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Done is a straight decode of the state register, so it cannot glitch.
    assign Done = (state == DONE);

endmodule

// File: tb/tb_unsigned_binary_divider.sv
// Self-checking bench for the sequential unsigned divider.
// Vector table, hand-written corner sequences and random model comparison.
module tb_unsigned_binary_divider;

    localparam int Q_W = 16;
    localparam int D_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               St;
    logic [Q_W+D_W-1:0] Dividend;
    logic [D_W-1:0]     Divisor;
    logic [Q_W-1:0]     Quotient;
    logic [D_W-1:0]     Remainder;
    logic               Ovf;
    logic               Done;

    unsigned_binary_divider #(.Q_W(Q_W), .D_W(D_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .St        (St),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Ovf       (Ovf),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [Q_W-1:0] pq;
    logic [D_W-1:0] pr;
    logic           povf;

    typedef struct {
        logic [19:0] a;
        logic [3:0]  b;
        logic [15:0] q;
        logic [3:0]  r;
        logic        ovf;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        else
            passed++;
    endtask

    // Run one division, checking latency, hold behaviour and results.
    task automatic run_exp(input logic [19:0] a, input logic [3:0] b,
                           input logic [15:0] eq, input logic [3:0] er,
                           input logic eovf, input string tag);
        int k;
        bit stable;
        int lat;
        lat = eovf ? 1 : Q_W + 1;
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
        St       = 1'b1;
        @(negedge clk);
        St       = 1'b0;
        Dividend = 20'($urandom);
        Divisor  = 4'($urandom);
        k        = 0;
        stable   = 1'b1;
        while (!Done && k < 40) begin
            if (Quotient !== pq || Remainder !== pr || Ovf !== povf)
                stable = 1'b0;
            @(negedge clk);
            k++;
        end
        chk({tag, " stable"}, 32'(stable), 32'd1);
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " quotient"}, 32'(Quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(Remainder), 32'(er));
        chk({tag, " ovf"}, 32'(Ovf), 32'(eovf));
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(Done), 32'd0);
        pq   = eq;
        pr   = er;
        povf = eovf;
    endtask

    initial begin
        int d1;
        int d2;
        int ndone;
        bit stable;
        logic [15:0] eq;
        logic [3:0]  er;
        logic        eovf;
        logic [19:0] a;
        logic [3:0]  b;
        int unsigned qq;

        tbl[0] = '{20'd200,   4'd7,  16'd28,     4'd4,  1'b0};
        tbl[1] = '{20'h0A3D4, 4'd9,  16'h1234,   4'd0,  1'b0};
        tbl[2] = '{20'hEFFFF, 4'd15, 16'hFFFF,   4'd14, 1'b0};
        tbl[3] = '{20'hF0000, 4'd15, 16'd0,      4'd0,  1'b1};
        tbl[4] = '{20'h12345, 4'd0,  16'd0,      4'd0,  1'b1};
        tbl[5] = '{20'h00000, 4'd0,  16'd0,      4'd0,  1'b1};
        tbl[6] = '{20'd100,   4'd3,  16'd33,     4'd1,  1'b0};
        tbl[7] = '{20'h6FFFF, 4'd7,  16'hFFFF,   4'd6,  1'b0};
        tbl[8] = '{20'h00000, 4'd1,  16'd0,      4'd0,  1'b0};
        tbl[9] = '{20'h9FFFF, 4'd9,  16'd0,      4'd0,  1'b1};

        rst      = 1'b1;
        St       = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        pq       = '0;
        pr       = '0;
        povf     = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset quotient", 32'(Quotient), 32'd0);
        chk("reset remainder", 32'(Remainder), 32'd0);
        chk("reset ovf", 32'(Ovf), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle done", 32'(Done), 32'd0);

        for (int i = 0; i < 10; i++)
            run_exp(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].ovf,
                    $sformatf("vec%0d", i));

        // St held high throughout two back-to-back divisions.
        @(negedge clk);
        Dividend = 20'h0A3D4;
        Divisor  = 4'd9;
        St       = 1'b1;
        @(negedge clk);
        Dividend = 20'h12345;
        Divisor  = 4'd7;
        d1       = -1;
        d2       = -1;
        ndone    = 0;
        stable   = 1'b1;
        for (int k = 0; k < 45; k++) begin
            if (Done) begin
                ndone++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (d1 < 0) begin
                eq = pq; er = pr; eovf = povf;
            end else if (d2 < 0) begin
                eq = 16'h1234; er = 4'd0; eovf = 1'b0;
            end else begin
                eq = 16'h299C; er = 4'd1; eovf = 1'b0;
            end
            if (Quotient !== eq || Remainder !== er || Ovf !== eovf)
                stable = 1'b0;
            if (k == 36) St = 1'b0;
            @(negedge clk);
        end
        St = 1'b0;
        chk("hold first done", 32'(d1), 32'd17);
        chk("hold second done", 32'(d2), 32'd36);
        chk("hold done count", 32'(ndone), 32'd2);
        chk("hold outputs", 32'(stable), 32'd1);
        pq   = 16'h299C;
        pr   = 4'd1;
        povf = 1'b0;

        // Reset in the middle of the DIV phase.
        @(negedge clk);
        Dividend = 20'd200;
        Divisor  = 4'd7;
        St       = 1'b1;
        @(negedge clk);
        St = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst quotient", 32'(Quotient), 32'd0);
        chk("midrst remainder", 32'(Remainder), 32'd0);
        chk("midrst ovf", 32'(Ovf), 32'd0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (Done) ndone++;
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (Done) ndone++;
        end
        chk("midrst no done", 32'(ndone), 32'd0);
        pq   = '0;
        pr   = '0;
        povf = 1'b0;
        run_exp(20'd100, 4'd3, 16'd33, 4'd1, 1'b0, "post_rst");

        // Random pairs against plain-arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            b = 4'($urandom_range(0, 15));
            a = 20'($urandom);
            if ($urandom_range(0, 3) != 0 && b != 0)
                a[19:16] = 4'($urandom_range(0, int'(b) - 1));
            if (b == 0) begin
                eovf = 1'b1; eq = '0; er = '0;
            end else begin
                qq = 32'(a) / 32'(b);
                if (qq > 32'hFFFF) begin
                    eovf = 1'b1; eq = '0; er = '0;
                end else begin
                    eovf = 1'b0;
                    eq   = 16'(qq);
                    er   = 4'(32'(a) % 32'(b));
                end
            end
            run_exp(a, b, eq, er, eovf, $sformatf("rnd%0d", i));
            if (!eovf) begin
                chk($sformatf("rnd%0d invariant", i),
                    32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
                chk($sformatf("rnd%0d rem_lt", i),
                    32'(Remainder < b), 32'd1);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
